// File: rtl/laplace_window_gen.sv
// Streaming cross-shaped 3x3 neighbourhood generator (b,d,e,f,h) for Laplace kernels.
// Optional macro LAPLACE_WIN_SOF_EN adds an in_sof input that re-aligns the frame origin.
module laplace_window_gen #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pix,
`ifdef LAPLACE_WIN_SOF_EN
  input  logic             in_sof,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_b,
  output logic [PIX_W-1:0] out_d,
  output logic [PIX_W-1:0] out_e,
  output logic [PIX_W-1:0] out_f,
  output logic [PIX_W-1:0] out_h,
  output logic             out_last
);

  localparam int CXW = $clog2(IMG_W);
  localparam int CYW = $clog2(IMG_H);
  localparam logic [CXW-1:0] X_LAST = CXW'(IMG_W - 1);
  localparam logic [CYW-1:0] Y_LAST = CYW'(IMG_H - 1);
  localparam logic [CXW-1:0] X_MIN  = CXW'(2);
  localparam logic [CYW-1:0] Y_MIN  = CYW'(2);

  logic [CXW-1:0]   cx_reg, cx_cur, cx_next;
  logic [CYW-1:0]   cy_reg, cy_cur, cy_next;
  logic [PIX_W-1:0] lb0 [IMG_W];
  logic [PIX_W-1:0] lb1 [IMG_W];
  logic [PIX_W-1:0] lb0_rd, lb1_rd;
  logic [PIX_W-1:0] top_reg, mid_l_reg, mid_reg, bot_reg;
  logic             accept, emit, frame_end;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

`ifdef LAPLACE_WIN_SOF_EN
  assign cx_cur = in_sof ? '0 : cx_reg;
  assign cy_cur = in_sof ? '0 : cy_reg;
`else
  assign cx_cur = cx_reg;
  assign cy_cur = cy_reg;
`endif

  // Line reads are combinational so the new column joins the window on the accepting edge.
  assign lb0_rd    = lb0[cx_cur];
  assign lb1_rd    = lb1[cx_cur];
  assign emit      = accept && (cx_cur >= X_MIN) && (cy_cur >= Y_MIN);
  assign frame_end = (cx_cur == X_LAST) && (cy_cur == Y_LAST);

  always_comb begin
    cx_next = cx_cur + 1'b1;
    cy_next = cy_cur;
    if (cx_cur == X_LAST) begin
      cx_next = '0;
      cy_next = (cy_cur == Y_LAST) ? '0 : cy_cur + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cx_reg <= '0;
      cy_reg <= '0;
    end else if (accept) begin
      cx_reg <= cx_next;
      cy_reg <= cy_next;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb0[cx_cur] <= lb1_rd;
      lb1[cx_cur] <= in_pix;
    end
  end

  // Only the window cells feeding the cross are kept: the right column of the top and
  // bottom rows plus the middle and right columns of the centre row.
  always_ff @(posedge clk) begin
    if (rst) begin
      top_reg   <= '0;
      mid_l_reg <= '0;
      mid_reg   <= '0;
      bot_reg   <= '0;
    end else if (accept) begin
      top_reg   <= lb0_rd;
      mid_l_reg <= mid_reg;
      mid_reg   <= lb1_rd;
      bot_reg   <= in_pix;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_b     <= '0;
      out_d     <= '0;
      out_e     <= '0;
      out_f     <= '0;
      out_h     <= '0;
    end else if (emit) begin
      out_valid <= 1'b1;
      out_last  <= frame_end;
      out_b     <= top_reg;
      out_d     <= mid_l_reg;
      out_e     <= mid_reg;
      out_f     <= lb1_rd;
      out_h     <= bot_reg;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_laplace_window_gen.sv
// Bench for laplace_window_gen: directed ramp frames checked against a table,
// plus randomized handshakes checked against an image-array reference model.
module tb_laplace_window_gen;

  localparam int W = 8;
  localparam int H = 6;
  localparam int NPIX = W * H;
  localparam int NOUT = (W - 2) * (H - 2);

  typedef struct packed {
    logic [7:0] b;
    logic [7:0] d;
    logic [7:0] e;
    logic [7:0] f;
    logic [7:0] h;
    logic       last;
  } nb_t;

  typedef struct {
    int idx;
    int b;
    int d;
    int e;
    int f;
    int h;
    bit last;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_pix;
`ifdef LAPLACE_WIN_SOF_EN
  logic       in_sof;
`endif
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_b, out_d, out_e, out_f, out_h;
  logic       out_last;

  int   n_vec = 0;
  int   n_err = 0;
  vec_t tbl [6];
  nb_t  exp_q [$];
  nb_t  got_q [$];
  logic [7:0] img [H][W];
  int   mx = 0, my = 0;
  int   acc_cnt = 0;
  int   first_valid_acc = -1;
  bit   hold_pending = 0;
  nb_t  held;

  laplace_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_pix(in_pix),
`ifdef LAPLACE_WIN_SOF_EN
    .in_sof(in_sof),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_b(out_b),
    .out_d(out_d),
    .out_e(out_e),
    .out_f(out_f),
    .out_h(out_h),
    .out_last(out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %h required %h (t=%0t)", nm, got, expv, $time);
    end
  endtask

  // Reference model: store every accepted pixel at its raster position and build the
  // cross centred one row up and one column left once both are available.
  always @(negedge clk) begin
    nb_t cur;
    nb_t ex;
    cur = '{b: out_b, d: out_d, e: out_e, f: out_f, h: out_h, last: out_last};
    if (rst) begin
      exp_q.delete();
      mx = 0;
      my = 0;
      acc_cnt = 0;
      first_valid_acc = -1;
      hold_pending = 0;
    end else begin
      chk("in_ready_rule", in_ready, !out_valid || out_ready);
      if (hold_pending) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", cur, held);
      end
      if (out_valid && first_valid_acc < 0) first_valid_acc = acc_cnt;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          ex = exp_q.pop_front();
          chk("model_output", cur, ex);
        end
        got_q.push_back(cur);
      end
      hold_pending = out_valid && !out_ready;
      held = cur;
      if (in_valid && in_ready) begin
`ifdef LAPLACE_WIN_SOF_EN
        if (in_sof) begin
          mx = 0;
          my = 0;
        end
`endif
        img[my][mx] = in_pix;
        if (mx >= 2 && my >= 2) begin
          ex.b = img[my-2][mx-1];
          ex.d = img[my-1][mx-2];
          ex.e = img[my-1][mx-1];
          ex.f = img[my-1][mx];
          ex.h = img[my][mx-1];
          ex.last = (mx == W - 1) && (my == H - 1);
          exp_q.push_back(ex);
        end
        acc_cnt++;
        mx++;
        if (mx == W) begin
          mx = 0;
          my = (my == H - 1) ? 0 : my + 1;
        end
      end
    end
  end

  task automatic send_pix(input logic [7:0] p, input bit sof);
    int guard;
    bit ok;
    guard = 0;
    ok = 0;
    in_valid = 1'b1;
    in_pix = p;
`ifdef LAPLACE_WIN_SOF_EN
    in_sof = sof;
`else
    if (sof) $display("note: start-of-frame input not built in");
`endif
    while (!ok && guard < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!ok) chk("accept_timeout", 0, 1);
`ifdef LAPLACE_WIN_SOF_EN
    in_sof = 1'b0;
`endif
  endtask

  task automatic send_frame(input int base, input int stall_at, input bit sof_first);
    for (int i = 0; i < NPIX; i++) begin
      if (i == stall_at) begin
        out_ready = 1'b0;
        fork
          begin
            repeat (2) @(posedge clk);
            #2;
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
            repeat (3) @(posedge clk);
            #1;
            out_ready = 1'b1;
          end
        join_none
      end
      send_pix(8'(base + i), sof_first && (i == 0));
    end
  endtask

  task automatic drain();
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("model_queue_empty", exp_q.size(), 0);
  endtask

  task automatic check_frame(input string nm, input int start, input int base);
    nb_t g, e;
    int nl;
    if (got_q.size() >= start + NOUT) begin
      foreach (tbl[i]) begin
        g = got_q[start + tbl[i].idx];
        e = '{b: 8'(tbl[i].b + base), d: 8'(tbl[i].d + base), e: 8'(tbl[i].e + base),
              f: 8'(tbl[i].f + base), h: 8'(tbl[i].h + base), last: tbl[i].last};
        chk($sformatf("%s_out%0d", nm, tbl[i].idx), g, e);
      end
      nl = 0;
      for (int k = 0; k < NOUT; k++) if (got_q[start + k].last) nl++;
      chk({nm, "_last_count"}, nl, 1);
    end else begin
      chk({nm, "_short"}, got_q.size() - start, NOUT);
    end
  endtask

  initial begin
    int s;
    int acc;
    int cyc;
    // Checkpoints of a ramp frame pix=y*8+x: output index -> expected cross.
    tbl[0] = '{0,  1,  8,  9,  10, 17, 1'b0};
    tbl[1] = '{1,  2,  9,  10, 11, 18, 1'b0};
    tbl[2] = '{5,  6,  13, 14, 15, 22, 1'b0};
    tbl[3] = '{6,  9,  16, 17, 18, 25, 1'b0};
    tbl[4] = '{12, 17, 24, 25, 26, 33, 1'b0};
    tbl[5] = '{23, 30, 37, 38, 39, 46, 1'b1};

    rst = 1'b1;
    in_valid = 1'b0;
    in_pix = '0;
    out_ready = 1'b1;
`ifdef LAPLACE_WIN_SOF_EN
    in_sof = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_last", out_last, 0);
    chk("reset_out_data", {out_b, out_d, out_e, out_f, out_h}, 0);
    chk("reset_in_ready", in_ready, 1);
    rst = 1'b0;

    // Plain ramp frame
    s = got_q.size();
    send_frame(0, -1, 1'b0);
    drain();
    chk("first_valid_after_accepts", first_valid_acc, 19);
    chk("ramp_count", got_q.size() - s, NOUT);
    check_frame("ramp", s, 0);

    // Same frame with a 5-clock downstream stall mid-line
    s = got_q.size();
    send_frame(0, 20, 1'b0);
    drain();
    chk("stall_count", got_q.size() - s, NOUT);
    check_frame("stall", s, 0);

    // Two frames back to back
    s = got_q.size();
    send_frame(0, -1, 1'b0);
    send_frame(64, -1, 1'b0);
    drain();
    chk("b2b_count", got_q.size() - s, 2 * NOUT);
    check_frame("b2b_f0", s, 0);
    check_frame("b2b_f1", s + NOUT, 64);

    // Partial frame, one reset clock, then a clean frame
    for (int i = 0; i < 30; i++) send_pix(8'(200 + i), 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset_out_valid", out_valid, 0);
    rst = 1'b0;
    s = got_q.size();
    send_frame(0, -1, 1'b0);
    drain();
    chk("after_reset_count", got_q.size() - s, NOUT);
    check_frame("after_reset", s, 0);

`ifdef LAPLACE_WIN_SOF_EN
    // 12 pixels of a frame, then a full frame flagged with in_sof
    for (int i = 0; i < 12; i++) send_pix(8'(100 + i), 1'b0);
    s = got_q.size();
    send_frame(0, -1, 1'b1);
    drain();
    chk("sof_count", got_q.size() - s, NOUT);
    check_frame("sof", s, 0);
`endif

    // Random pixels and random handshakes over three frames
    acc = 0;
    cyc = 0;
    while (acc < 3 * NPIX && cyc < 5000) begin
      in_valid = ($urandom_range(3) != 0);
      in_pix = 8'($urandom);
      out_ready = ($urandom_range(2) != 0);
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("rand_accepts", acc, 3 * NPIX);
    out_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
